// File: rtl/req_initiator_if.sv
// rtl/req_initiator_if.sv - packet types and host/execution-unit bus bundle for req_initiator
//
// Purpose : shares the request/response packet structs and groups every
//           handshake and bus signal of req_initiator into one interface.
// Modports: master - the initiator (drives cmd_ready/cmd_id, req_out,
//                    completions, status)
//           slave  - the host plus execution unit (drives commands,
//                    fifo_full, rsp_in)
// Signals : cmd_valid/cmd_ready/cmd_type/cmd_data1/cmd_data2/cmd_id  host commands
//           req_out/fifo_full                 request to execution unit
//           rsp_in                            response from execution unit
//           cpl_valid/cpl_id/cpl_type/cpl_data/cpl_err   completion to host
//           outstanding/idle/timeout          status

package req_initiator_pkg;

  typedef struct packed {
    logic        req;
    logic        req_type;
    logic [2:0]  req_id;
    logic [31:0] req_data1;
    logic [31:0] req_data2;
  } req_pkt_type;

  typedef struct packed {
    logic        rsp;
    logic [2:0]  rsp_id;
    logic [63:0] rsp_data;
  } rsp_pkt_type;

endpackage

interface req_initiator_if;
  import req_initiator_pkg::*;

  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_type;
  logic [31:0] cmd_data1;
  logic [31:0] cmd_data2;
  logic [2:0]  cmd_id;
  req_pkt_type req_out;
  logic        fifo_full;
  rsp_pkt_type rsp_in;
  logic        cpl_valid;
  logic [2:0]  cpl_id;
  logic        cpl_type;
  logic [63:0] cpl_data;
  logic        cpl_err;
  logic [2:0]  outstanding;
  logic        idle;
  logic        timeout;

  modport master (
    input  cmd_valid, cmd_type, cmd_data1, cmd_data2, fifo_full, rsp_in,
    output cmd_ready, cmd_id, req_out, cpl_valid, cpl_id, cpl_type, cpl_data,
           cpl_err, outstanding, idle, timeout
  );

  modport slave (
    output cmd_valid, cmd_type, cmd_data1, cmd_data2, fifo_full, rsp_in,
    input  cmd_ready, cmd_id, req_out, cpl_valid, cpl_id, cpl_type, cpl_data,
           cpl_err, outstanding, idle, timeout
  );

endinterface

// File: rtl/req_initiator.sv
// rtl/req_initiator.sv - ID-tracking command initiator towards an add/mul execution unit
//
// Purpose : accepts host commands, tags each one with the lowest free ID
//           (1..7), issues it once to the execution unit, and matches
//           responses back to IDs to produce host completions.
// Ports   : clk   - single clock, posedge
//           rst_b - asynchronous active-low reset
//           bus   - req_initiator_if.master (commands, req_out, fifo_full,
//                   rsp_in, completions, outstanding/idle/timeout)
// Options : REQ_TIMEOUT_EN - builds the watchdog counter that drives the
//           sticky timeout flag; when undefined, timeout is tied low.

module req_initiator
  import req_initiator_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 7,
  parameter int TIMEOUT_CYCLES  = 255
) (
  input  logic             clk,
  input  logic             rst_b,
  req_initiator_if.master  bus
);

  typedef enum logic {ST_IDLE, ST_PEND} state_t;

  localparam logic [2:0] MAX_OUT = 3'(MAX_OUTSTANDING);

  state_t      state_q, state_d;
  // Bit 0 is never set: ID 0 is reserved as "no ID".
  logic [7:0]  busy_q, busy_d;
  logic [7:0]  type_q, type_d;

  logic        pay_type_q, pay_type_d;
  logic [2:0]  pay_id_q, pay_id_d;
  logic [31:0] pay_data1_q, pay_data1_d;
  logic [31:0] pay_data2_q, pay_data2_d;

  logic        cpl_valid_q, cpl_valid_d;
  logic        cpl_err_q, cpl_err_d;
  logic        cpl_type_q, cpl_type_d;
  logic [2:0]  cpl_id_q, cpl_id_d;
  logic [63:0] cpl_data_q, cpl_data_d;

  logic [2:0]  alloc_id;
  logic [2:0]  busy_cnt;
  logic        sent;
  logic        cmd_ready_w;
  logic        accept;
  logic        rsp_ok;
  req_pkt_type req_w;

  // Lowest free ID and busy popcount, both from the registered (pre-free)
  // busy vector, so an ID released this cycle is not handed out again
  // until the next one.
  always_comb begin
    alloc_id = 3'd0;
    busy_cnt = 3'd0;
    for (int i = 7; i >= 1; i--) begin
      if (!busy_q[i]) alloc_id = 3'(i);
    end
    for (int i = 1; i <= 7; i++) begin
      busy_cnt = busy_cnt + {2'b00, busy_q[i]};
    end
  end

  assign sent        = (state_q == ST_PEND) && !bus.fifo_full;
  // rst_b gates ready so nothing is offered while reset is held.
  assign cmd_ready_w = rst_b && (alloc_id != 3'd0) && (busy_cnt < MAX_OUT) &&
                       ((state_q == ST_IDLE) || sent);
  assign accept      = bus.cmd_valid && cmd_ready_w;
  assign rsp_ok      = bus.rsp_in.rsp && busy_q[bus.rsp_in.rsp_id];

  // Issue FSM: one request slot, refilled in the same cycle it drains.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_PEND;
      ST_PEND: if (sent && !accept) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pay_type_d  = pay_type_q;
    pay_id_d    = pay_id_q;
    pay_data1_d = pay_data1_q;
    pay_data2_d = pay_data2_q;
    busy_d      = busy_q;
    type_d      = type_q;
    if (rsp_ok) busy_d[bus.rsp_in.rsp_id] = 1'b0;
    if (accept) begin
      busy_d[alloc_id] = 1'b1;
      type_d[alloc_id] = bus.cmd_type;
      pay_type_d       = bus.cmd_type;
      pay_id_d         = alloc_id;
      pay_data1_d      = bus.cmd_data1;
      pay_data2_d      = bus.cmd_data2;
    end
    busy_d[0] = 1'b0;
    type_d[0] = 1'b0;
  end

  always_comb begin
    cpl_valid_d = rsp_ok;
    cpl_err_d   = bus.rsp_in.rsp && !rsp_ok;
    cpl_id_d    = bus.rsp_in.rsp_id;
    cpl_type_d  = type_q[bus.rsp_in.rsp_id];
    cpl_data_d  = bus.rsp_in.rsp_data;
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q     <= ST_IDLE;
      busy_q      <= '0;
      type_q      <= '0;
      pay_type_q  <= 1'b0;
      pay_id_q    <= '0;
      pay_data1_q <= '0;
      pay_data2_q <= '0;
      cpl_valid_q <= 1'b0;
      cpl_err_q   <= 1'b0;
      cpl_type_q  <= 1'b0;
      cpl_id_q    <= '0;
      cpl_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      type_q      <= type_d;
      pay_type_q  <= pay_type_d;
      pay_id_q    <= pay_id_d;
      pay_data1_q <= pay_data1_d;
      pay_data2_q <= pay_data2_d;
      cpl_valid_q <= cpl_valid_d;
      cpl_err_q   <= cpl_err_d;
      cpl_type_q  <= cpl_type_d;
      cpl_id_q    <= cpl_id_d;
      cpl_data_q  <= cpl_data_d;
    end
  end

  always_comb begin
    req_w.req       = sent;
    req_w.req_type  = pay_type_q;
    req_w.req_id    = pay_id_q;
    req_w.req_data1 = pay_data1_q;
    req_w.req_data2 = pay_data2_q;
  end

  assign bus.req_out     = req_w;
  assign bus.cmd_ready   = cmd_ready_w;
  assign bus.cmd_id      = alloc_id;
  assign bus.cpl_valid   = cpl_valid_q;
  assign bus.cpl_err     = cpl_err_q;
  assign bus.cpl_id      = cpl_id_q;
  assign bus.cpl_type    = cpl_type_q;
  assign bus.cpl_data    = cpl_data_q;
  assign bus.outstanding = busy_cnt;
  assign bus.idle        = (busy_cnt == 3'd0) && (state_q == ST_IDLE);

`ifdef REQ_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] tcnt_q, tcnt_d;
  logic          timeout_q, timeout_d;

  // Counts cycles without progress while anything is in flight; saturates
  // at the limit and the flag stays set until reset.
  always_comb begin
    tcnt_d = tcnt_q;
    if (rsp_ok || (busy_cnt == 3'd0)) tcnt_d = '0;
    else if (tcnt_q != CW'(TIMEOUT_CYCLES)) tcnt_d = tcnt_q + 1'b1;
    timeout_d = timeout_q || (tcnt_d == CW'(TIMEOUT_CYCLES));
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      tcnt_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      tcnt_q    <= tcnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.timeout = timeout_q;
`else
  assign bus.timeout = 1'b0;
`endif

endmodule

// File: tb/tb_req_initiator.sv
// tb/tb_req_initiator.sv - randomized and directed self-checking bench for req_initiator

module tb_req_initiator;
  import req_initiator_pkg::*;

  localparam int MAXO = 7;
  localparam int TO   = 10;

  logic clk = 1'b0;
  logic rst_b = 1'b0;
  always #5 clk = ~clk;

  req_initiator_if u_if();

  req_initiator #(.MAX_OUTSTANDING(MAXO), .TIMEOUT_CYCLES(TO)) dut (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (u_if.master)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: per-ID busy/type tables, a queue of accepted but not
  // yet issued requests, and the completion expected on the next cycle.
  bit          m_busy[8];
  bit          m_type[8];
  req_pkt_type pq[$];
  bit          e_cv, e_ce, e_ct;
  logic [2:0]  e_cid;
  logic [63:0] e_cd;
  int          tcnt;
  bit          mto;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int m_count();
    int n = 0;
    for (int i = 1; i < 8; i++) n += int'(m_busy[i]);
    return n;
  endfunction

  function automatic logic [2:0] m_lowest();
    for (int i = 1; i < 8; i++) if (!m_busy[i]) return 3'(i);
    return 3'd0;
  endfunction

  task automatic m_clear();
    for (int i = 0; i < 8; i++) begin
      m_busy[i] = 1'b0;
      m_type[i] = 1'b0;
    end
    pq.delete();
    e_cv = 0; e_ce = 0; e_ct = 0; e_cid = 0; e_cd = 0;
    tcnt = 0; mto = 0;
  endtask

  task automatic set_idle();
    u_if.cmd_valid = 1'b0;
    u_if.cmd_type  = 1'b0;
    u_if.cmd_data1 = '0;
    u_if.cmd_data2 = '0;
    u_if.fifo_full = 1'b0;
    u_if.rsp_in    = '0;
  endtask

  task automatic set_cmd(input bit t, input logic [31:0] a, input logic [31:0] b);
    u_if.cmd_valid = 1'b1;
    u_if.cmd_type  = t;
    u_if.cmd_data1 = a;
    u_if.cmd_data2 = b;
  endtask

  task automatic set_rsp(input logic [2:0] id, input logic [63:0] d);
    u_if.rsp_in = '{rsp: 1'b1, rsp_id: id, rsp_data: d};
  endtask

  // One clock: compare outputs against the model mid-cycle, advance the
  // model by what the coming edge should do, return just after the edge.
  task automatic cycle();
    int          n;
    logic [2:0]  lo;
    bit          rdy, ereq, acc, ok;
    logic [2:0]  rid;
    req_pkt_type p;
    @(negedge clk);
    n    = m_count();
    lo   = m_lowest();
    rdy  = (n < MAXO) && (lo != 3'd0) && (pq.size() == 0 || !u_if.fifo_full);
    ereq = (pq.size() > 0) && !u_if.fifo_full;
    check("cmd_ready", u_if.cmd_ready, rdy);
    if (u_if.cmd_valid && rdy) check("cmd_id", u_if.cmd_id, lo);
    check("req", u_if.req_out.req, ereq);
    if (pq.size() > 0) begin
      check("req_hdr", {u_if.req_out.req_type, u_if.req_out.req_id}, {pq[0].req_type, pq[0].req_id});
      check("req_data", {u_if.req_out.req_data1, u_if.req_out.req_data2}, {pq[0].req_data1, pq[0].req_data2});
    end
    check("outstanding", u_if.outstanding, n);
    check("idle", u_if.idle, (n == 0) && (pq.size() == 0));
    check("cpl_valid", u_if.cpl_valid, e_cv);
    check("cpl_err", u_if.cpl_err, e_ce);
    if (e_cv) begin
      check("cpl_id", u_if.cpl_id, e_cid);
      check("cpl_type", u_if.cpl_type, e_ct);
      check("cpl_data", u_if.cpl_data, e_cd);
    end
    check("timeout", u_if.timeout, mto);

    acc   = u_if.cmd_valid && rdy;
    rid   = u_if.rsp_in.rsp_id;
    ok    = u_if.rsp_in.rsp && (rid != 3'd0) && m_busy[rid];
    e_cv  = ok;
    e_ce  = u_if.rsp_in.rsp && !ok;
    e_cid = rid;
    e_ct  = m_type[rid];
    e_cd  = u_if.rsp_in.rsp_data;
`ifdef REQ_TIMEOUT_EN
    if (ok || n == 0) tcnt = 0;
    else if (tcnt < TO) tcnt++;
    if (tcnt == TO) mto = 1;
`endif
    if (ok) m_busy[rid] = 1'b0;
    if (ereq) void'(pq.pop_front());
    if (acc) begin
      m_busy[lo]  = 1'b1;
      m_type[lo]  = u_if.cmd_type;
      p.req       = 1'b1;
      p.req_type  = u_if.cmd_type;
      p.req_id    = lo;
      p.req_data1 = u_if.cmd_data1;
      p.req_data2 = u_if.cmd_data2;
      pq.push_back(p);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_b = 1'b0;
    set_idle();
    u_if.cmd_valid = 1'b1;
    @(negedge clk);
    check("rst_cmd_ready", u_if.cmd_ready, 0);
    check("rst_req", u_if.req_out.req, 0);
    check("rst_req_hdr", {u_if.req_out.req_type, u_if.req_out.req_id}, 0);
    check("rst_req_data", {u_if.req_out.req_data1, u_if.req_out.req_data2}, 0);
    check("rst_cpl", {u_if.cpl_valid, u_if.cpl_err}, 0);
    check("rst_outstanding", u_if.outstanding, 0);
    check("rst_timeout", u_if.timeout, 0);
    check("rst_idle", u_if.idle, 1);
    u_if.cmd_valid = 1'b0;
    m_clear();
    @(posedge clk);
    #1;
    rst_b = 1'b1;
  endtask

  initial begin
    logic [2:0] old_id;
    set_idle();
    m_clear();

    // Basic add: 3+4 issued with ID 1, completion returns data 7.
    do_reset();
    set_cmd(1'b0, 32'd3, 32'd4);
    #1 check("t32_cmd_id", u_if.cmd_id, 1);
    cycle();
    u_if.cmd_valid = 1'b0;
    #1;
    check("t32_req", u_if.req_out.req, 1);
    check("t32_req_id", u_if.req_out.req_id, 1);
    check("t32_req_type", u_if.req_out.req_type, 0);
    cycle();
    set_rsp(3'd1, 64'd7);
    cycle();
    u_if.rsp_in = '0;
    #1;
    check("t32_cpl", {u_if.cpl_valid, u_if.cpl_id, u_if.cpl_type}, {1'b1, 3'd1, 1'b0});
    check("t32_cpl_data", u_if.cpl_data, 64'd7);
    cycle();

    // Back-pressure: request held off for 5 cycles then issued exactly once.
    set_cmd(1'b1, $urandom, $urandom);
    cycle();
    u_if.cmd_valid = 1'b0;
    u_if.fifo_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("t33_stall_req", u_if.req_out.req, 0);
      check("t33_stall_ready", u_if.cmd_ready, 0);
      cycle();
    end
    u_if.fifo_full = 1'b0;
    #1 check("t33_release_req", u_if.req_out.req, 1);
    cycle();
    #1 check("t33_single_pulse", u_if.req_out.req, 0);
    cycle();

    // Fill all seven IDs, then a freed ID is the next one allocated.
    do_reset();
    for (int i = 1; i <= 7; i++) begin
      set_cmd(1'($urandom), $urandom, $urandom);
      #1 check("t34_cmd_id", u_if.cmd_id, i);
      cycle();
    end
    u_if.cmd_valid = 1'b0;
    #1;
    check("t34_outstanding", u_if.outstanding, 7);
    check("t34_ready_full", u_if.cmd_ready, 0);
    cycle();
    set_rsp(3'd4, {$urandom, $urandom});
    cycle();
    u_if.rsp_in = '0;
    set_cmd(1'b1, $urandom, $urandom);
    #1 check("t34_reuse_id", u_if.cmd_id, 4);
    cycle();
    u_if.cmd_valid = 1'b0;
    cycle();

    // Unexpected responses: ID 0 and a free ID each raise cpl_err only.
    do_reset();
    set_cmd(1'b0, $urandom, $urandom);
    cycle();
    u_if.cmd_valid = 1'b0;
    cycle();
    set_rsp(3'd0, 64'd1);
    cycle();
    u_if.rsp_in = '0;
    #1;
    check("t35_err_id0", {u_if.cpl_err, u_if.cpl_valid}, 2'b10);
    check("t35_outstanding0", u_if.outstanding, 1);
    set_rsp(3'd5, 64'd2);
    cycle();
    u_if.rsp_in = '0;
    #1;
    check("t35_err_free", {u_if.cpl_err, u_if.cpl_valid}, 2'b10);
    check("t35_outstanding5", u_if.outstanding, 1);
    cycle();

    // Free and allocate in the same cycle: freed ID 1 is not reused.
    do_reset();
    set_cmd(1'b0, $urandom, $urandom);
    cycle();
    set_cmd(1'b1, $urandom, $urandom);
    cycle();
    u_if.cmd_valid = 1'b0;
    cycle();
    set_rsp(3'd1, {$urandom, $urandom});
    set_cmd(1'b0, $urandom, $urandom);
    #1 check("t36_cmd_id", u_if.cmd_id, 3);
    cycle();
    set_idle();
    #1 check("t36_outstanding", u_if.outstanding, 2);
    cycle();
    cycle();

`ifdef REQ_TIMEOUT_EN
    // Watchdog: one request never answered.
    do_reset();
    set_cmd(1'b0, $urandom, $urandom);
    cycle();
    u_if.cmd_valid = 1'b0;
    for (int i = 0; i < 12; i++) cycle();
    check("t37_timeout", u_if.timeout, 1);
`endif

    // Randomized traffic.
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      u_if.cmd_valid = ($urandom_range(0, 1) == 1);
      u_if.cmd_type  = 1'($urandom);
      u_if.cmd_data1 = $urandom;
      u_if.cmd_data2 = $urandom;
      u_if.fifo_full = ($urandom_range(0, 3) == 0);
      u_if.rsp_in    = '0;
      if ($urandom_range(0, 2) == 0) begin
        logic [2:0] id;
        id = 3'($urandom_range(0, 7));
        if ($urandom_range(0, 4) != 0 && m_count() > 0) begin
          while (!m_busy[id] || id == 3'd0) id = 3'($urandom_range(1, 7));
        end
        set_rsp(id, {$urandom, $urandom});
      end
      cycle();
    end

    // Reset mid-operation: a response for a pre-reset ID is unexpected.
    set_idle();
    old_id = 3'd1;
    for (int i = 7; i >= 1; i--) if (m_busy[i]) old_id = 3'(i);
    do_reset();
    set_rsp(old_id, 64'hdead);
    cycle();
    u_if.rsp_in = '0;
    #1 check("t29_stale_err", {u_if.cpl_err, u_if.cpl_valid}, 2'b10);
    cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
